spi_wb_arb: RTL
===============

SPI_WB_ARB -- requirements
Module: spi_wb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the watchdog limit in cycles; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have parameter ADDR_W, default 5, the Wishbone register address width of the SPI master.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_adr_i / m1_adr_i, input, ADDR_W: address from requester 0 (XIP sequencer) and requester 1 (APB pass-through).
REQ-006 SHALL have ports m0_dat_i / m1_dat_i, input, 32: write data.
REQ-007 SHALL have ports m0_sel_i / m1_sel_i, input, 4: byte enables.
REQ-008 SHALL have ports m0_we_i, m0_stb_i, m0_cyc_i and m1_we_i, m1_stb_i, m1_cyc_i, input, 1 each: Wishbone controls.
REQ-009 SHALL have port m0_lock_i, input, 1: when high, requester 0 keeps the grant across cyc gaps.
REQ-010 SHALL have ports m0_dat_o / m1_dat_o, output, 32, and m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, output, 1 each: responses.
REQ-011 SHALL have ports s_adr_o (ADDR_W), s_dat_o (32), s_sel_o (4), and s_we_o, s_stb_o, s_cyc_o (1 each), output: drive the SPI master slave port.
REQ-012 SHALL have ports s_dat_i (32), s_ack_i (1), s_err_i (1), input: the SPI master response.
REQ-013 SHALL have port gnt_o, output, 2: one-hot grant, bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, GNT0 and GNT1.
REQ-015 IDLE SHALL move to GNT0 if only m0_cyc_i is high, to GNT1 if only m1_cyc_i is high, and to the requester not granted last if both are high (round-robin).
REQ-016 Grant SHALL take effect the cycle after a request is sampled, giving 1-cycle arbitration latency.
REQ-017 While in GNTx, s_* outputs SHALL equal the granted requester's inputs combinationally; in IDLE, s_stb_o, s_cyc_o and s_we_o SHALL be 0.
REQ-018 The granted requester SHALL receive s_ack_i, s_err_i and s_dat_i combinationally; the other requester SHALL see ack=0, err=0 and dat=0.
REQ-019 GNT1 SHALL return to IDLE on the edge where m1_cyc_i is low.
REQ-020 GNT0 SHALL return to IDLE on the edge where m0_cyc_i and m0_lock_i are both low.
REQ-021 A requester whose cyc is raised while the other holds the grant SHALL wait with no ack; it is never preempted mid-lock.
REQ-022 Every release SHALL pass through IDLE for exactly one bubble cycle before the next grant.
REQ-023 The last-grant register SHALL update on entry to GNTx.

Reset
REQ-024 When reset is low, the FSM SHALL enter IDLE and last-grant SHALL be set to m1, so m0 wins the first tie.
REQ-025 During reset, gnt_o=00, all ack/err outputs=0 and s_cyc_o=s_stb_o=0; this holds even mid-transaction.

Configuration
REQ-026 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL clear on state change or s_ack_i and increment while granted with stb high and no ack.
REQ-027 With SPI_ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES-1 the arbiter SHALL pulse the granted requester's err_o for 1 cycle, force s_cyc_o=s_stb_o=0 and go to IDLE, ignoring m0_lock_i.
REQ-028 Without SPI_ARB_TIMEOUT_EN, no counter SHALL exist and err_o SHALL reflect only s_err_i.

Structure
REQ-029 Package spi_arb_pkg SHALL hold the state enum, the grant one-hot constants and the TIMEOUT_CYCLES default.
REQ-030 Sub-module spi_arb_wdt (the timeout counter) SHALL be instantiated only under SPI_ARB_TIMEOUT_EN; the FSM and muxes SHALL stay in spi_wb_arb.

Verification
REQ-031 m1 write adr=0x18, dat=0x1, alone -> gnt_o=10 the next cycle, s_adr_o=0x18, m1_ack_o mirrors s_ack_i, then IDLE one cycle after cyc drops.
REQ-032 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after release, m1 granted following the 1-cycle bubble.
REQ-033 m0_lock_i high across 4 transactions (adr 0x04, 0x14, 0x18, 0x10) with m1 requesting throughout -> gnt_o stays 01 through all cyc gaps; m1 is granted only after lock drops.
REQ-034 reset asserted during GNT0 with stb high -> gnt_o=00 and s_cyc_o=0 immediately (asynchronous); after release, IDLE is re-entered.
REQ-035 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks -> m0_err_o pulses for 1 cycle at the 8th cycle, then the FSM goes to IDLE.
REQ-036 Without the macro, the same stimulus as REQ-035 -> no err pulse and the grant is held indefinitely.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI Wishbone arbiter.
// Holds the arbiter FSM state enum, the one-hot grant encodings, bus widths
// and the default watchdog limit. The watchdog is only built when
// SPI_ARB_TIMEOUT_EN is defined.
package spi_arb_pkg;

  localparam int unsigned DAT_W              = 32;
  localparam int unsigned SEL_W              = 4;
  localparam int unsigned GNT_W              = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  // One-hot grant: bit0 = requester 0 (XIP), bit1 = requester 1 (APB)
  localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
  localparam logic [GNT_W-1:0] GNT_M0   = 2'b01;
  localparam logic [GNT_W-1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spi_wb_arb_if.sv
// Bus bundle between the two Wishbone requesters, the arbiter and the SPI
// master slave port.
//   m0_* / m1_*   : requester 0 (XIP sequencer) and requester 1 (APB bridge)
//   s_*           : arbitrated port toward the SPI master
//   gnt_o         : one-hot grant status
// Modport slave is the arbiter view; modport master is the requester/slave
// environment view.
interface spi_wb_arb_if #(
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0]              m0_adr_i;
  logic [spi_arb_pkg::DAT_W-1:0]  m0_dat_i;
  logic [spi_arb_pkg::SEL_W-1:0]  m0_sel_i;
  logic                           m0_we_i;
  logic                           m0_stb_i;
  logic                           m0_cyc_i;
  logic                           m0_lock_i;
  logic [spi_arb_pkg::DAT_W-1:0]  m0_dat_o;
  logic                           m0_ack_o;
  logic                           m0_err_o;

  logic [ADDR_W-1:0]              m1_adr_i;
  logic [spi_arb_pkg::DAT_W-1:0]  m1_dat_i;
  logic [spi_arb_pkg::SEL_W-1:0]  m1_sel_i;
  logic                           m1_we_i;
  logic                           m1_stb_i;
  logic                           m1_cyc_i;
  logic [spi_arb_pkg::DAT_W-1:0]  m1_dat_o;
  logic                           m1_ack_o;
  logic                           m1_err_o;

  logic [ADDR_W-1:0]              s_adr_o;
  logic [spi_arb_pkg::DAT_W-1:0]  s_dat_o;
  logic [spi_arb_pkg::SEL_W-1:0]  s_sel_o;
  logic                           s_we_o;
  logic                           s_stb_o;
  logic                           s_cyc_o;
  logic [spi_arb_pkg::DAT_W-1:0]  s_dat_i;
  logic                           s_ack_i;
  logic                           s_err_i;

  logic [spi_arb_pkg::GNT_W-1:0]  gnt_o;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_lock_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i, s_err_i,
    output gnt_o
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_lock_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i, s_err_i,
    input  gnt_o
  );

endinterface

// File: rtl/spi_arb_wdt.sv
// Watchdog counter for a granted transfer that the SPI master never acks.
// Ports:
//   clock, reset : clock and async active-low reset
//   clr_i        : restart the count (grant change or slave ack)
//   inc_i        : granted, strobe high and no ack this cycle
//   expired_c    : combinational; high in the cycle the limit is reached
// Only instantiated when SPI_ARB_TIMEOUT_EN is defined.
module spi_arb_wdt
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // The n-th stalled cycle sees a count of n-1, so expiry lands on cycle TIMEOUT_CYCLES
  assign expired_c = inc_i && (cnt_q == CNT_LAST);

  // Stall counter; holds at the limit since the grant drops that same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_wb_arb.sv
// Two-requester Wishbone arbiter in front of the SPI master register port.
// Requester 0 is the XIP sequencer (may lock the grant across cyc gaps),
// requester 1 is the APB pass-through. Round-robin on ties, one idle bubble
// between grants, 1-cycle arbitration latency.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : spi_wb_arb_if.slave (requester ports, SPI master port, gnt_o)
// Parameters:
//   TIMEOUT_CYCLES : watchdog limit, only used with SPI_ARB_TIMEOUT_EN
//   ADDR_W         : Wishbone register address width
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort transfers that go
// unacknowledged for TIMEOUT_CYCLES cycles with a 1-cycle err pulse.
module spi_wb_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ADDR_W         = 5
) (
  input  logic         clock,
  input  logic         reset,
  spi_wb_arb_if.slave  bus
);

  // A limit below 2 leaves no room for a stalled cycle before expiry
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_wb_arb: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic       last_m1_q, last_m1_d;
  logic       timeout_c;

`ifdef SPI_ARB_TIMEOUT_EN
  logic req_stb_c;
  logic wdt_clr_c;

  // Granted requester is strobing and the slave has not answered
  assign req_stb_c = ((state_q == ST_GNT0) && bus.m0_stb_i) ||
                     ((state_q == ST_GNT1) && bus.m1_stb_i);
  assign wdt_clr_c = (state_d != state_q) || bus.s_ack_i;

  spi_arb_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (wdt_clr_c),
    .inc_i     (req_stb_c && !bus.s_ack_i),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // State and last-grant registers; last grant starts at m1 so m0 wins the first tie
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Next-state decode and grant-steered muxes
  always_comb begin
    state_d      = state_q;
    last_m1_d    = last_m1_q;
    bus.gnt_o    = GNT_NONE;
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_we_o   = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_cyc_o  = 1'b0;
    bus.m0_dat_o = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d   = last_m1_q ? ST_GNT0 : ST_GNT1;
          last_m1_d = !last_m1_q;
        end else if (bus.m0_cyc_i) begin
          state_d   = ST_GNT0;
          last_m1_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d   = ST_GNT1;
          last_m1_d = 1'b1;
        end
      end

      ST_GNT0: begin
        bus.gnt_o    = GNT_M0;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_stb_o  = bus.m0_stb_i && !timeout_c;
        bus.s_cyc_o  = bus.m0_cyc_i && !timeout_c;
        bus.m0_dat_o = bus.s_dat_i;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = bus.s_err_i || timeout_c;
        // Lock holds the grant through cyc gaps; a watchdog abort overrides it
        if (timeout_c || (!bus.m0_cyc_i && !bus.m0_lock_i)) begin
          state_d = ST_IDLE;
        end
      end

      ST_GNT1: begin
        bus.gnt_o    = GNT_M1;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_stb_o  = bus.m1_stb_i && !timeout_c;
        bus.s_cyc_o  = bus.m1_cyc_i && !timeout_c;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = bus.s_err_i || timeout_c;
        if (timeout_c || !bus.m1_cyc_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
